multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Main sequencer for the multicycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback states. In every cycle it drives the shared ALU's `alu_op`, its operand selects, and all register, PC and memory enables. The ALU control unit consumes `alu_op` together with the instruction's funct3/funct7 fields.

## Interface
- `ALU_OP_W`, default 2: width of `alu_op`. Encoding:
  - 00: add (address/PC arithmetic)
  - 01: branch compare
  - 10: R-type
  - 11: I-type ALU
- `clk` input 1: the block's single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 7: instruction-register bits [6:0]; valid from DECODE onward.
- `funct3` input 3: instruction-register bits [14:12].
- `alu_zero` input 1: ALU result == 0 (combinational, from the current cycle).
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `mem_read` output 1: memory read request; held until `mem_ready`.
- `mem_write` output 1: memory write request; held until `mem_ready`.
- `i_or_d` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write` output 1: latch the instruction register and old_pc.
- `pc_write` output 1: load the PC.
- `pc_src` output 1: PC source. 0 = live ALU result, 1 = ALUOut register.
- `reg_write` output 1: register file write enable for rd.
- `alu_op` output 2: ALU operation class, encoded as above.
- `alu_src_a` output 2: ALU operand A. 00 = PC, 01 = old_pc, 10 = rs1.
- `alu_src_b` output 2: ALU operand B. 00 = rs2, 01 = imm, 10 = constant 4.
- `result_src` output 2: writeback source. 00 = ALUOut, 01 = mem data, 10 = PC (already +4), 11 = imm.
- `instr_done` output 1: one-cycle pulse in the final cycle of each instruction.
- `halted` output 1: sticky; set on entering HALT.

## Operation
- States, 4-bit encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, JALR=11, UPPER=12, HALT=15
- FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=PC, `alu_src_b`=4, `alu_op`=00.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1 with `pc_src`=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Computes old_pc+imm into ALUOut (`alu_src_a`=01, `alu_src_b`=01, `alu_op`=00).
  - Next state by opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 or 0010111 → UPPER
    - 0001111 (FENCE) → FETCH, as a NOP; pulses `instr_done`.
    - 1110011 and any other opcode → HALT.
- MEM_ADDR: computes rs1+imm (`alu_src_a`=10, `alu_src_b`=01, `alu_op`=00). Next state is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_read`=1 with `i_or_d`=1. On `mem_ready` go to MEM_WB.
- MEM_WB: `reg_write`=1 with `result_src`=01, pulses `instr_done`, then FETCH.
- MEM_WR: `mem_write`=1 with `i_or_d`=1. On `mem_ready` pulse `instr_done` and go to FETCH.
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10, then ALU_WB.
- EXEC_I: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=11, then ALU_WB.
- ALU_WB: `reg_write`=1 with `result_src`=00, pulses `instr_done`, then FETCH.
- BRANCH:
  - ALU setup: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01.
  - taken = (funct3[2] ? ~alu_zero : alu_zero) XOR funct3[0].
  - Drives `pc_write`=taken with `pc_src`=1; pulses `instr_done`; then FETCH.
- JAL: `reg_write`=1 with `result_src`=10 (rd = PC+4), `pc_write`=1 with `pc_src`=1. Pulses `instr_done`, then FETCH.
- JALR:
  - ALU setup: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - Writes `reg_write`=1 with `result_src`=10, and `pc_write`=1 with `pc_src`=0, in the same cycle. The datapath clears bit 0.
  - Pulses `instr_done`, then FETCH.
- UPPER: `reg_write`=1. `result_src`=11 when opcode is LUI, 00 when opcode is AUIPC (ALUOut = old_pc+imm). Pulses `instr_done`, then FETCH.
- HALT:
  - Terminal state; all enables are 0; `halted`=1.
  - Only `rst` leaves HALT.
- Any output not listed for a state is 0.

## Timing
- Reset:
  - While `rst` is high, state is forced to FETCH on the next edge.
  - During the `rst` cycle, `mem_read`, `mem_write`, `ir_write`, `pc_write`, `reg_write` and `instr_done` are forced to 0. `halted` clears.
  - Reset in any state, including mid-memory-wait, aborts the instruction with no writes.
- All outputs decode combinationally from state. Mealy terms: `mem_ready` gates `ir_write`/`pc_write` in FETCH; `alu_zero`/`funct3` gate `pc_write` in BRANCH.
- Cycle counts with `mem_ready` tied high:
  - R/I-type: 4
  - load: 5
  - store: 4
  - branch, JAL, JALR, LUI, AUIPC: 3
  - FENCE: 2
- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Requests and addresses are held stable during the wait.
- `instr_done` is exactly one cycle per retired instruction. It never fires for a halting opcode.

## Test plan
- Reset, then `opcode`=0110011 (R-type), `mem_ready`=1:
  - state sequence 0,1,6,8,0
  - `alu_op`=10 in EXEC_R
  - `reg_write`=1 only in ALU_WB
  - `instr_done` on cycle 4
- Load (0000011) with `mem_ready` low for 2 cycles in MEM_RD:
  - `mem_read`/`i_or_d`=1 held for 3 cycles
  - total of 7 cycles
  - `result_src`=01 in MEM_WB
- Branch sweep over funct3 000, 001, 100, 101, 110, 111 with `alu_zero`=0 and 1:
  - `pc_write` matches the taken equation
  - e.g. BEQ with zero=1 → 1; BGE with zero=0 → 0
  - `alu_op`=01 in all cases
- Fetch stall: `mem_ready`=0 for 5 cycles → `ir_write`=`pc_write`=0 throughout, asserted only on the ready cycle.
- `opcode`=1110011 → HALT: `halted`=1 and all enables 0 for 20 cycles; `rst` pulse → FETCH and `halted`=0.
- `rst` asserted in MEM_WR while waiting on `mem_ready`: next state FETCH, no `mem_write` in the reset cycle, no `instr_done`.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath enable and select.
module multicycle_control_fsm #(
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          result_src,
    output logic                instr_done,
    output logic                halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2'b00);
    localparam logic [ALU_OP_W-1:0] ALU_BR  = ALU_OP_W'(2'b01);
    localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(2'b10);
    localparam logic [ALU_OP_W-1:0] ALU_I   = ALU_OP_W'(2'b11);

    state_t state_q, state_d;

    // Ungated request/enable terms; reset masks them below.
    logic rd_req, wr_req, ir_we, pc_we, rf_we, done, taken;

    // funct3[1] only distinguishes signed/unsigned compares, which the ALU handles.
    logic unused_funct3_bit;
    assign unused_funct3_bit = funct3[1];

    assign taken = (funct3[2] ? ~alu_zero : alu_zero) ^ funct3[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        done       = 1'b0;
        i_or_d     = 1'b0;
        pc_src     = 1'b0;
        alu_op     = ALU_ADD;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;

        unique case (state_q)
            S_FETCH: begin
                rd_req    = 1'b1;
                alu_src_b = 2'b10;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    OP_FENCE: begin
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end
                    default:           state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                rd_req = 1'b1;
                i_or_d = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                rf_we      = 1'b1;
                result_src = 2'b01;
                done       = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                wr_req = 1'b1;
                i_or_d = 1'b1;
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_R;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALU_I;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                rf_we   = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_BR;
                pc_we     = taken;
                pc_src    = 1'b1;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                rf_we      = 1'b1;
                result_src = 2'b10;
                pc_we      = 1'b1;
                pc_src     = 1'b1;
                done       = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                rf_we      = 1'b1;
                result_src = 2'b10;
                pc_we      = 1'b1;
                done       = 1'b1;
                state_d    = S_FETCH;
            end
            S_UPPER: begin
                rf_we      = 1'b1;
                result_src = (opcode == OP_LUI) ? 2'b11 : 2'b00;
                done       = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Reset aborts whatever is in flight: no request, write or retirement escapes.
    assign mem_read   = rd_req & ~rst;
    assign mem_write  = wr_req & ~rst;
    assign ir_write   = ir_we  & ~rst;
    assign pc_write   = pc_we  & ~rst;
    assign reg_write  = rf_we  & ~rst;
    assign instr_done = done   & ~rst;
    assign halted     = (state_q == S_HALT) & ~rst;

endmodule
